// File: rtl/spi_slave_pkg.sv
// spi_pkg: default widths, FSM state encoding and R/W flag values shared by the spi_slave files
package spi_pkg;
  localparam int DATA_WIDTH_D = 32;
  localparam int ADDR_WIDTH_D = 16;
  localparam logic WRITE = 1'b1;
  localparam logic READ = 1'b0;
  typedef enum logic [2:0] {IDLE, FLAG, ADDR, GAP, DATA, DONE} spi_state_t;
endpackage

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI pins plus register-bank handshake; slave modport for spi_slave, master modport for the driving side
interface spi_slave_if #(parameter int DATA_WIDTH = 32, parameter int ADDR_WIDTH = 16);
  logic CS;
  logic SCK;
  logic MOSI;
  logic MISO;
  logic [DATA_WIDTH-1:0] TXData;
  logic TXDataValid;
  logic RWType;
  logic [DATA_WIDTH-1:0] RXData;
  logic RXDataValid;
  logic [ADDR_WIDTH-1:0] RXAddr;
  logic RXAddrValid;
  logic RXAck;
  modport slave (
    input CS, SCK, MOSI, TXData, TXDataValid,
    output MISO, RWType, RXData, RXDataValid, RXAddr, RXAddrValid, RXAck
  );
  modport master (
    output CS, SCK, MOSI, TXData, TXDataValid,
    input MISO, RWType, RXData, RXDataValid, RXAddr, RXAddrValid, RXAck
  );
endinterface

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: 2-FF synchronizer (clk, d -> q) plus rise/fall pulses; left unreset so a pin held low across reset never reads as a fresh edge
module spi_sync_edge (
  input  logic clk,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [2:0] s;
  always_ff @(posedge clk) s <= {s[1:0], d};
  always_comb begin
    q = s[1];
    rise = s[1] & ~s[2];
    fall = ~s[1] & s[2];
  end
endmodule

// File: rtl/spi_slave.sv
// spi_slave: mode-3 SPI slave to register bank; ports Clk, Rst (sync, active-high) and bus (spi_slave_if.slave: CS/SCK/MOSI/MISO, TX/RX data, addr, valids, RWType, RXAck)
module spi_slave
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_D,
  parameter int ADDR_WIDTH = ADDR_WIDTH_D
) (
  input logic Clk,
  input logic Rst,
  spi_slave_if.slave bus
);
  localparam int CW = $clog2(DATA_WIDTH > ADDR_WIDTH ? DATA_WIDTH : ADDR_WIDTH);
  spi_state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [ADDR_WIDTH-1:0] addr_sr;
  logic [DATA_WIDTH-1:0] data_sr;
  logic [DATA_WIDTH-1:0] tx_sr;
  logic [1:0] mosi_s;
  logic mosi;
  logic sck_rise, sck_fall, cs_rise, cs_fall;
  logic sck_q_unused, cs_q_unused;
  logic addr_done, data_done, tx_open;
  logic tx_loaded, tx_started;
  spi_sync_edge u_sck (.clk(Clk), .d(bus.SCK), .q(sck_q_unused), .rise(sck_rise), .fall(sck_fall));
  spi_sync_edge u_cs (.clk(Clk), .d(bus.CS), .q(cs_q_unused), .rise(cs_rise), .fall(cs_fall));
  always_ff @(posedge Clk) mosi_s <= {mosi_s[0], bus.MOSI};
  assign mosi = mosi_s[1];
  always_ff @(posedge Clk)
    if (Rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    addr_done = state == ADDR && sck_rise && cnt == CW'(ADDR_WIDTH - 1);
    data_done = state == DATA && sck_rise && cnt == CW'(DATA_WIDTH - 1);
    tx_open = addr_done || state == GAP || (state == DATA && !tx_started);
    state_n = state;
    if (cs_rise) state_n = IDLE;
    else if (state == IDLE && cs_fall) state_n = FLAG;
    else if (state == FLAG && sck_rise) state_n = ADDR;
    else if (addr_done) state_n = GAP;
    else if (state == GAP && sck_rise) state_n = DATA;
    else if (data_done) state_n = DONE;
  end
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt <= '0;
      addr_sr <= '0;
      data_sr <= '0;
      tx_sr <= '0;
      tx_loaded <= 1'b0;
      tx_started <= 1'b0;
      bus.MISO <= 1'b0;
      bus.RWType <= 1'b0;
      bus.RXAddr <= '0;
      bus.RXData <= '0;
      bus.RXAddrValid <= 1'b0;
      bus.RXDataValid <= 1'b0;
      bus.RXAck <= 1'b0;
    end else begin
      cnt <= state_n != state ? '0 : cnt + CW'(sck_rise);
      bus.RXAddrValid <= addr_done;
      bus.RXDataValid <= data_done && bus.RWType == WRITE;
      bus.RXAck <= data_done;
      if (state == FLAG && sck_rise) bus.RWType <= mosi;
      if (state == ADDR && sck_rise) addr_sr <= {mosi, addr_sr[ADDR_WIDTH-1:1]};
      if (addr_done) bus.RXAddr <= {mosi, addr_sr[ADDR_WIDTH-1:1]};
      if (state == DATA && sck_rise) data_sr <= {mosi, data_sr[DATA_WIDTH-1:1]};
      if (data_done && bus.RWType == WRITE) bus.RXData <= {mosi, data_sr[DATA_WIDTH-1:1]};
      bus.MISO <= state != DATA ? 1'b0 : sck_fall ? tx_sr[0] : bus.MISO;
      if (cs_fall) begin
        tx_sr <= '0;
        tx_loaded <= 1'b0;
        tx_started <= 1'b0;
      end else if (state == DATA && sck_fall) begin
        tx_sr <= tx_sr >> 1;
        tx_started <= 1'b1;
      end else if (tx_open && bus.TXDataValid && !tx_loaded && bus.RWType == READ) begin
        tx_sr <= bus.TXData;
        tx_loaded <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_spi_slave.sv
// tb_spi_slave: scoreboard bench for spi_slave driving SPI frames and modelling the register bank
module tb_spi_slave;
  typedef struct packed {logic rw; logic [15:0] addr;} addr_t;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int acks = 0;
  bit bank_en = 1'b1;
  addr_t exp_a[$];
  logic [31:0] exp_d[$];
  logic [31:0] exp_r[$];
  logic [31:0] ref_mem[logic [15:0]];
  logic [31:0] mem[logic [15:0]];
  logic [15:0] addrs[16];
  spi_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) bus ();
  spi_slave dut (.Clk(Clk), .Rst(Rst), .bus(bus));
  always #5 Clk = ~Clk;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask
  initial forever begin
    @(negedge Clk);
    if (bus.RXAddrValid) begin
      chk("addr_pending", 64'(exp_a.size() > 0), 1);
      if (exp_a.size() > 0) chk("rxaddr", {bus.RWType, bus.RXAddr}, exp_a.pop_front());
    end
    if (bus.RXDataValid) begin
      chk("data_pending", 64'(exp_d.size() > 0), 1);
      if (exp_d.size() > 0) chk("rxdata", bus.RXData, exp_d.pop_front());
    end
    if (bus.RXAck) acks++;
  end
  initial forever begin
    @(negedge Clk);
    if (bus.RXDataValid) mem[bus.RXAddr] = bus.RXData;
    if (bus.TXDataValid) bus.TXDataValid = 1'b0;
    else if (bus.RXAddrValid && !bus.RWType && bank_en) begin
      bus.TXData = mem.exists(bus.RXAddr) ? mem[bus.RXAddr] : 32'h0;
      bus.TXDataValid = 1'b1;
    end
  end
  task automatic frame(input logic rw, input logic [15:0] a, input logic [31:0] d, input int n, input bit tie_cs);
    logic [49:0] b;
    logic [31:0] rd;
    int a0;
    b = {d, 1'b0, a, rw};
    rd = '0;
    a0 = acks;
    if (n >= 17) exp_a.push_back({rw, a});
    if (n == 50 && rw) begin
      exp_d.push_back(d);
      ref_mem[a] = d;
    end
    bus.CS = 1'b0;
    #80;
    for (int s = 0; s < n; s++) begin
      bus.SCK = 1'b0;
      bus.MOSI = b[s];
      #80;
      if (s >= 18) rd[s-18] = bus.MISO;
      bus.SCK = 1'b1;
      if (tie_cs && s == n - 1) bus.CS = 1'b1;
      #80;
    end
    bus.CS = 1'b1;
    bus.MOSI = 1'b0;
    #160;
    chk("ack", 64'(acks - a0), 64'(n == 50));
    if (!rw && n == 50) chk("rdata", rd, exp_r.pop_front());
  endtask
  task automatic wr(input logic [15:0] a, input logic [31:0] d);
    frame(1'b1, a, d, 50, 1'b0);
  endtask
  task automatic rd(input logic [15:0] a);
    exp_r.push_back(!bank_en ? 32'h0 : ref_mem.exists(a) ? ref_mem[a] : 32'h0);
    frame(1'b0, a, 32'h0, 50, 1'b0);
  endtask
  initial begin
    bus.CS = 1'b1;
    bus.SCK = 1'b1;
    bus.MOSI = 1'b0;
    bus.TXData = '0;
    bus.TXDataValid = 1'b0;
    repeat (5) @(negedge Clk);
    chk("reset", {bus.MISO, bus.RWType, bus.RXAddr, bus.RXData, bus.RXAddrValid, bus.RXDataValid, bus.RXAck}, 0);
    Rst = 1'b0;
    repeat (4) @(negedge Clk);
    wr(16'h1234, 32'hDEADBEEF);
    chk("rwtype_w", bus.RWType, 1);
    rd(16'h1234);
    chk("rwtype_r", bus.RWType, 0);
    rd(16'h0001);
    frame(1'b1, 16'h0002, 32'h1357_9BDF, 29, 1'b0);
    chk("abort_hold", bus.RXData, 32'hDEADBEEF);
    frame(1'b1, 16'h0002, 32'h0000_00FF, 50, 1'b1);
    rd(16'h0002);
    for (int i = 0; i < 16; i++) begin
      addrs[i] = 16'(16'h40 + $urandom_range(0, 7));
      wr(addrs[i], $urandom);
    end
    for (int i = 0; i < 16; i++) rd(addrs[i]);
    bank_en = 1'b0;
    rd(16'h1234);
    bank_en = 1'b1;
    bus.CS = 1'b0;
    #80;
    for (int s = 0; s < 8; s++) begin
      bus.SCK = 1'b0;
      bus.MOSI = s[0];
      #80;
      bus.SCK = 1'b1;
      #80;
    end
    @(negedge Clk);
    Rst = 1'b1;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    chk("rst_mid", {bus.MISO, bus.RWType, bus.RXAddr, bus.RXData, bus.RXAddrValid, bus.RXDataValid, bus.RXAck}, 0);
    repeat (20) @(negedge Clk);
    chk("rst_idle", {bus.RXAddrValid, bus.RXAddr}, 0);
    bus.CS = 1'b1;
    #160;
    wr(16'h0003, 32'h5A5A5A5A);
    chk("rxdata_hold", bus.RXData, 32'h5A5A5A5A);
    chk("sb_left", 64'(exp_a.size() + exp_d.size() + exp_r.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
